// File: rtl/alu_pkg.sv
// Shared widths and command/result records for the ALU command front-end.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int SEL_W  = 3;

  // One queued ALU operation.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [SEL_W-1:0]  sel;
    logic              use_acc;
  } alu_cmd_t;

  // One registered ALU outcome.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              carry;
    logic              zero;
    logic [SEL_W-1:0]  sel;
  } alu_res_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command, ALU and result buses of the sequencer. The slave view is the
// sequencer itself; the master view is whatever drives and consumes it.
interface alu_cmd_sequencer_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic                       cmd_valid;
  logic                       cmd_ready;
  logic [alu_pkg::DATA_W-1:0] cmd_a;
  logic [alu_pkg::DATA_W-1:0] cmd_b;
  logic [alu_pkg::SEL_W-1:0]  cmd_sel;
  logic                       cmd_use_acc;

  logic [alu_pkg::DATA_W-1:0] alu_a;
  logic [alu_pkg::DATA_W-1:0] alu_b;
  logic [alu_pkg::SEL_W-1:0]  alu_sel;
  logic [alu_pkg::DATA_W-1:0] alu_out;
  logic                       alu_carry;
  logic                       alu_zero;

  logic                       res_valid;
  logic                       res_ready;
  logic [alu_pkg::DATA_W-1:0] res_data;
  logic                       res_carry;
  logic                       res_zero;
  logic [alu_pkg::SEL_W-1:0]  res_sel;

  logic [CNT_W-1:0]           fifo_count;
  logic                       busy;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc,
    input  alu_out, alu_carry, alu_zero, res_ready,
    output cmd_ready, alu_a, alu_b, alu_sel,
    output res_valid, res_data, res_carry, res_zero, res_sel,
    output fifo_count, busy
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_sel, cmd_use_acc,
    output alu_out, alu_carry, alu_zero, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_sel,
    input  res_valid, res_data, res_carry, res_zero, res_sel,
    input  fifo_count, busy
  );
endinterface

// File: rtl/alu_cmd_fifo.sv
// Synchronous command FIFO. Pointers wrap modulo the power-of-two depth;
// occupancy is tracked in a separate counter so full/empty are trivial.
module alu_cmd_fifo
  import alu_pkg::*;
#(
  parameter  int FIFO_DEPTH = 4,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic             pop_i,
  input  alu_cmd_t         din_i,
  output alu_cmd_t         dout_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CNT_W-1:0] count_o
);

  alu_cmd_t         mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(FIFO_DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign dout_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Occupancy moves only on push-xor-pop.
  always_comb begin
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage needs no reset: entries are only read once counted valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

  // Pointer and occupancy state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// ALU command front-end: FIFO -> execute register (drives the external ALU)
// -> result register with valid/ready. The accumulator holds the last
// captured result so a command can take it as operand A.
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  alu_cmd_sequencer_if.slave  bus
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  alu_cmd_t          cmd_in, fifo_head, e_cmd_q;
  alu_res_t          r_q;
  logic              e_vld_q, e_vld_d, r_vld_q, r_vld_d;
  logic [DATA_W-1:0] acc_q, alu_a_hold_q, alu_a_d;
  logic              fifo_full, fifo_empty, push, e_load, r_cap;
  logic [CNT_W-1:0]  fifo_cnt;

  assign cmd_in = '{a: bus.cmd_a, b: bus.cmd_b, sel: bus.cmd_sel,
                    use_acc: bus.cmd_use_acc};

  // Full FIFO refuses even when a pop happens the same cycle.
  assign bus.cmd_ready = !fifo_full;
  assign push          = bus.cmd_valid && !fifo_full;

  // R takes E when it is empty or being drained; E refills from the head
  // only once its current command is leaving, so acc is always up to date.
  assign r_cap  = e_vld_q && (!r_vld_q || bus.res_ready);
  assign e_load = !fifo_empty && (!e_vld_q || r_cap);

  alu_cmd_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push),
    .pop_i   (e_load),
    .din_i   (cmd_in),
    .dout_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  // ALU operand A; held in a register so it does not toggle while E is idle
  // even though acc changes as the last command leaves E.
  assign alu_a_d     = e_cmd_q.use_acc ? acc_q : e_cmd_q.a;
  assign bus.alu_a   = e_vld_q ? alu_a_d : alu_a_hold_q;
  assign bus.alu_b   = e_cmd_q.b;
  assign bus.alu_sel = e_cmd_q.sel;

  // Stage valid next-state.
  always_comb begin
    e_vld_d = e_vld_q;
    r_vld_d = r_vld_q;
    if (e_load)     e_vld_d = 1'b1;
    else if (r_cap) e_vld_d = 1'b0;
    if (r_cap)              r_vld_d = 1'b1;
    else if (bus.res_ready) r_vld_d = 1'b0;
  end

  // Execute stage and operand-A hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_vld_q      <= 1'b0;
      e_cmd_q      <= '0;
      alu_a_hold_q <= '0;
    end else begin
      e_vld_q <= e_vld_d;
      if (e_load)  e_cmd_q      <= fifo_head;
      if (e_vld_q) alu_a_hold_q <= alu_a_d;
    end
  end

  // Result stage and accumulator, both loaded from the ALU on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_q <= 1'b0;
      r_q     <= '0;
      acc_q   <= '0;
    end else begin
      r_vld_q <= r_vld_d;
      if (r_cap) begin
        r_q   <= '{data: bus.alu_out, carry: bus.alu_carry,
                   zero: bus.alu_zero, sel: e_cmd_q.sel};
        acc_q <= bus.alu_out;
      end
    end
  end

  assign bus.res_valid  = r_vld_q;
  assign bus.res_data   = r_q.data;
  assign bus.res_carry  = r_q.carry;
  assign bus.res_zero   = r_q.zero;
  assign bus.res_sel    = r_q.sel;
  assign bus.fifo_count = fifo_cnt;
  assign bus.busy       = !fifo_empty || e_vld_q || r_vld_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: XOR stub ALU, in-order result queue model.
module tb_alu_cmd_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_cmd_sequencer_if #(.FIFO_DEPTH(4)) ifc ();

  alu_cmd_sequencer #(.FIFO_DEPTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  // Stub ALU.
  assign ifc.alu_out   = ifc.alu_a ^ ifc.alu_b;
  assign ifc.alu_carry = ifc.alu_a[7] & ifc.alu_b[7];
  assign ifc.alu_zero  = (ifc.alu_out == 8'h00);

  typedef struct {
    logic [7:0] d;
    logic       c;
    logic       z;
    logic [2:0] s;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] m_acc = 8'h00;
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_res = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: commands complete strictly in acceptance order; each one's
  // operand A is either its own a or the previous command's result.
  task automatic model_push(input logic [7:0] a, input logic [7:0] b,
                            input logic [2:0] s, input logic ua);
    exp_t       e;
    logic [7:0] opa;
    opa = ua ? m_acc : a;
    e.d = opa ^ b;
    e.c = opa[7] & b[7];
    e.z = (e.d == 8'h00);
    e.s = s;
    m_acc = e.d;
    exp_q.push_back(e);
  endtask

  // Handshakes are observed mid-cycle, before the edge that completes them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifc.res_valid && ifc.res_ready) begin
        if (exp_q.size() == 0) chk("res_spurious", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          n_res++;
          chk("res_data",  ifc.res_data,  e.d);
          chk("res_carry", ifc.res_carry, e.c);
          chk("res_zero",  ifc.res_zero,  e.z);
          chk("res_sel",   ifc.res_sel,   e.s);
        end
      end
      if (ifc.cmd_valid && ifc.cmd_ready)
        model_push(ifc.cmd_a, ifc.cmd_b, ifc.cmd_sel, ifc.cmd_use_acc);
    end
  end

  // Offer one command; returns 1 time unit after the accepting edge.
  task automatic push_cmd(input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] s, input logic ua);
    bit done;
    done = 1'b0;
    ifc.cmd_a = a; ifc.cmd_b = b; ifc.cmd_sel = s; ifc.cmd_use_acc = ua;
    ifc.cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (ifc.cmd_ready) done = 1'b1;
      @(posedge clk); #1;
    end
    ifc.cmd_valid = 1'b0;
    if (!done) chk("push_timeout", 0, 1);
  endtask

  task automatic push_rand();
    push_cmd(8'($urandom), 8'($urandom), 3'($urandom), 1'($urandom));
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [7:0] held;
    bit         seen;
    ifc.cmd_valid = 0; ifc.cmd_a = 0; ifc.cmd_b = 0; ifc.cmd_sel = 0;
    ifc.cmd_use_acc = 0; ifc.res_ready = 0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    cyc(); cyc();

    // 1: idle after reset
    chk("rst_cmd_ready", ifc.cmd_ready, 1);
    chk("rst_res_valid", ifc.res_valid, 0);
    chk("rst_count",     ifc.fifo_count, 0);
    chk("rst_busy",      ifc.busy, 0);
    chk("rst_alu_a",     ifc.alu_a, 0);
    chk("rst_res_data",  ifc.res_data, 0);

    // 2: single command latency and contents
    ifc.res_ready = 1'b1;
    push_cmd(8'hE2, 8'h5D, 3'b010, 1'b0);
    chk("t2_count_n",   ifc.fifo_count, 1);
    chk("t2_valid_n",   ifc.res_valid, 0);
    cyc();
    chk("t2_valid_n1",  ifc.res_valid, 0);
    chk("t2_alu_a",     ifc.alu_a, 8'hE2);
    chk("t2_alu_b",     ifc.alu_b, 8'h5D);
    cyc();
    chk("t2_valid_n2",  ifc.res_valid, 1);
    chk("t2_data",      ifc.res_data, 8'hBF);
    chk("t2_carry",     ifc.res_carry, 0);
    chk("t2_zero",      ifc.res_zero, 0);
    chk("t2_sel",       ifc.res_sel, 3'b010);
    cyc();
    chk("t2_drained",   ifc.res_valid, 0);
    chk("t2_alu_a_hold", ifc.alu_a, 8'hE2);

    // 3: accumulator chain, back-to-back
    push_cmd(8'hF0, 8'h0F, 3'b001, 1'b0);
    push_cmd(8'h00, 8'hFF, 3'b011, 1'b1);
    cyc();
    chk("t3_first",  ifc.res_data, 8'hFF);
    chk("t3_first_v", ifc.res_valid, 1);
    cyc();
    chk("t3_second", ifc.res_data, 8'h00);
    chk("t3_zero",   ifc.res_zero, 1);
    chk("t3_carry",  ifc.res_carry, 1);
    cyc();

    // 4: backpressure fills E, R and the FIFO
    ifc.res_ready = 1'b0;
    repeat (6) push_rand();
    chk("t4_count",     ifc.fifo_count, 4);
    chk("t4_cmd_ready", ifc.cmd_ready, 0);
    chk("t4_res_valid", ifc.res_valid, 1);
    held = exp_q[0].d;
    repeat (3) begin
      cyc();
      chk("t4_hold", ifc.res_data, held);
    end
    ifc.res_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t4_stream_valid", ifc.res_valid, 1);
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("t4_empty_after", ifc.res_valid, 0);
    cyc();

    // 5: push+pop at count 2, then wrap with sequenced commands
    ifc.res_ready = 1'b0;
    repeat (4) push_rand();
    chk("t5_count_pre", ifc.fifo_count, 2);
    ifc.res_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      push_cmd(8'(8'h10 + i), 8'($urandom), 3'(i), 1'b0);
      chk("t5_count_steady", ifc.fifo_count, 2);
    end
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      cyc();
      if (!ifc.busy) seen = 1'b1;
    end
    chk("t5_drain_idle", seen, 1);
    chk("t5_queue_empty", exp_q.size(), 0);

    // 6: reset with work in flight
    ifc.res_ready = 1'b0;
    repeat (4) push_rand();
    chk("t6_pre_valid", ifc.res_valid, 1);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", ifc.res_valid, 0);
    chk("t6_rst_count", ifc.fifo_count, 0);
    chk("t6_rst_busy",  ifc.busy, 0);
    chk("t6_rst_ready", ifc.cmd_ready, 1);
    exp_q.delete();
    m_acc = 8'h00;
    @(negedge clk) rst_n = 1'b1;
    cyc();
    ifc.res_ready = 1'b1;
    push_cmd(8'($urandom), 8'h55, 3'b101, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (ifc.res_valid) seen = 1'b1;
      else cyc();
    end
    chk("t6_res_seen", seen, 1);
    chk("t6_acc_zero", ifc.res_data, 8'h55);
    cyc(); cyc();
    chk("end_queue_empty", exp_q.size(), 0);
    chk("end_n_results", n_res, 24);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
